// File: rtl/cbfp_norm.sv
// cbfp_norm: block floating-point normaliser.
//
// Input beats carry LANES complex samples (IW-bit signed re/im). Every
// BLK_BEATS accepted beats form a block. The block exponent E is the smallest
// count of redundant sign bits over every component of the block, clipped to
// EXP_MAX. Each component is then shifted by E-(IW-OW) and truncated to OW
// bits. Two ping-pong banks let a new block be written while the previous
// one is read out, so back-to-back blocks run at full rate.
//
// Build option: define CBFP_ROUND_EN to make right shifts round half up and
// saturate to the OW-bit range. Without it, right shifts truncate toward
// minus infinity and do not saturate. Left shifts are identical in both builds.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   clr                synchronous abort of the partial input block and any
//                      pending output
//   di_valid           input beat qualifier (gaps allowed, no backpressure)
//   di_re, di_im       LANES x IW input beat, lane i at [i*IW +: IW]
//   do_valid, do_last  output beat qualifier, final beat of an output block
//   do_re, do_im       LANES x OW normalised beat, lane i at [i*OW +: OW]
//   do_exp             clipped block exponent, stable across its block

module cbfp_norm #(
  parameter int unsigned IW        = 23,
  parameter int unsigned OW        = 11,
  parameter int unsigned LANES     = 16,
  parameter int unsigned BLK_BEATS = 4,
  parameter int unsigned EXP_MAX   = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    di_valid,
  input  logic [LANES*IW-1:0]     di_re,
  input  logic [LANES*IW-1:0]     di_im,
  output logic                    do_valid,
  output logic                    do_last,
  output logic [LANES*OW-1:0]     do_re,
  output logic [LANES*OW-1:0]     do_im,
  output logic [$clog2(IW)-1:0]   do_exp
);

  localparam int unsigned EW      = $clog2(IW);
  localparam int unsigned CW      = $clog2(BLK_BEATS);
  localparam int unsigned AW      = CW + 1;
  localparam int unsigned DEPTH   = 2 * BLK_BEATS;
  localparam int unsigned SH_BASE = IW - OW;

  localparam logic [CW-1:0] LAST_BEAT = CW'(BLK_BEATS - 1);
  localparam logic [EW-1:0] MIN_INIT  = EW'(IW - 1);
  localparam logic [EW-1:0] EXP_CLIP  = EW'(EXP_MAX);

`ifdef CBFP_ROUND_EN
  localparam logic signed [IW:0] SAT_HI = (IW+1)'((2 ** (OW - 1)) - 1);
  localparam logic signed [IW:0] SAT_LO = ~SAT_HI;
`endif

  // Count of bits directly below the MSB that equal the MSB.
  function automatic logic [EW-1:0] red_bits(input logic [IW-1:0] x);
    logic [EW-1:0] n;
    logic          run;
    n   = '0;
    run = 1'b1;
    for (int i = IW - 2; i >= 0; i--) begin
      if (run && (x[i] == x[IW-1])) n = n + EW'(1);
      else                          run = 1'b0;
    end
    return n;
  endfunction

  // Shift one component by e-(IW-OW) and keep the low OW bits.
  function automatic logic [OW-1:0] norm_one(input logic [IW-1:0] x,
                                             input logic [EW-1:0] e);
    logic signed [IW:0] ext;
    logic signed [IW:0] sh;
    logic [EW-1:0]      amt;
`ifdef CBFP_ROUND_EN
    logic signed [IW:0] rnd;
    rnd = '0;
`endif
    ext = $signed({x[IW-1], x});
    sh  = ext;
    amt = '0;
    if (e >= EW'(SH_BASE)) begin
      // Redundant sign bits guarantee the result fits in OW bits.
      amt = e - EW'(SH_BASE);
      sh  = ext <<< amt;
    end else begin
      amt = EW'(SH_BASE) - e;
`ifdef CBFP_ROUND_EN
      rnd = (IW+1)'(1) <<< (amt - EW'(1));
      sh  = (ext + rnd) >>> amt;
      if (sh > SAT_HI)      sh = SAT_HI;
      else if (sh < SAT_LO) sh = SAT_LO;
`else
      sh  = ext >>> amt;
`endif
    end
    return sh[OW-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Input side: beat counter, running minimum, bank select, block exponent
  // ---------------------------------------------------------------------------
  logic [CW-1:0] wr_cnt;
  logic          wr_bank;
  logic [EW-1:0] run_min;
  logic [EW-1:0] rd_exp;
  logic [EW-1:0] beat_min;
  logic [EW-1:0] blk_min;
  logic [EW-1:0] blk_exp;
  logic          accept;
  logic          last_beat;

  assign accept    = di_valid & ~clr;
  assign last_beat = accept && (wr_cnt == LAST_BEAT);

  // Minimum redundant-sign count over all components of the current beat.
  always_comb begin : beat_min_p
    logic [EW-1:0] l;
    l        = '0;
    beat_min = MIN_INIT;
    for (int i = 0; i < int'(LANES); i++) begin
      l = red_bits(di_re[i*IW +: IW]);
      if (l < beat_min) beat_min = l;
      l = red_bits(di_im[i*IW +: IW]);
      if (l < beat_min) beat_min = l;
    end
  end

  // Beat 0 restarts the minimum; later beats fold into it.
  always_comb begin
    blk_min = beat_min;
    if ((wr_cnt != '0) && (run_min < beat_min)) blk_min = run_min;
    blk_exp = (blk_min > EXP_CLIP) ? EXP_CLIP : blk_min;
  end

  // Write-side state; the block exponent is captured with the final beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      run_min <= MIN_INIT;
      rd_exp  <= '0;
    end else if (clr) begin
      wr_cnt  <= '0;
      run_min <= MIN_INIT;
    end else if (di_valid) begin
      wr_cnt  <= wr_cnt + CW'(1);
      run_min <= blk_min;
      if (wr_cnt == LAST_BEAT) begin
        wr_bank <= ~wr_bank;
        rd_exp  <= blk_exp;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Ping-pong sample storage, addressed {bank, beat}
  // ---------------------------------------------------------------------------
  logic [LANES*IW-1:0] mem_re [DEPTH];
  logic [LANES*IW-1:0] mem_im [DEPTH];

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re[AW'({wr_bank, wr_cnt})] <= di_re;
      mem_im[AW'({wr_bank, wr_cnt})] <= di_im;
    end
  end

  // ---------------------------------------------------------------------------
  // Read side stage 1: sequence through the completed bank
  // ---------------------------------------------------------------------------
  logic                rd_active;
  logic [CW-1:0]       rd_ptr;
  logic                rd_bank;
  logic                s1_valid;
  logic                s1_last;
  logic [LANES*IW-1:0] s1_re;
  logic [LANES*IW-1:0] s1_im;
  logic [EW-1:0]       s1_exp;

  // A new block start overrides the tail of the previous readout; at full
  // rate both happen on the same edge, which is what keeps beats contiguous.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_active <= 1'b0;
      rd_ptr    <= '0;
      rd_bank   <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_re     <= '0;
      s1_im     <= '0;
      s1_exp    <= '0;
    end else begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      if (clr) begin
        rd_active <= 1'b0;
        rd_ptr    <= '0;
      end else begin
        if (rd_active) begin
          s1_valid <= 1'b1;
          s1_last  <= (rd_ptr == LAST_BEAT);
          s1_re    <= mem_re[AW'({rd_bank, rd_ptr})];
          s1_im    <= mem_im[AW'({rd_bank, rd_ptr})];
          s1_exp   <= rd_exp;
          rd_ptr   <= rd_ptr + CW'(1);
          if (rd_ptr == LAST_BEAT) rd_active <= 1'b0;
        end
        if (last_beat) begin
          rd_active <= 1'b1;
          rd_ptr    <= '0;
          rd_bank   <= wr_bank;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read side stage 2: normalise and register the outputs
  // ---------------------------------------------------------------------------
  logic [LANES*OW-1:0] nrm_re;
  logic [LANES*OW-1:0] nrm_im;

  always_comb begin
    nrm_re = '0;
    nrm_im = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      nrm_re[i*OW +: OW] = norm_one(s1_re[i*IW +: IW], s1_exp);
      nrm_im[i*OW +: OW] = norm_one(s1_im[i*IW +: IW], s1_exp);
    end
  end

  // Data and exponent hold between valid beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      do_valid <= 1'b0;
      do_last  <= 1'b0;
      do_re    <= '0;
      do_im    <= '0;
      do_exp   <= '0;
    end else if (clr) begin
      do_valid <= 1'b0;
      do_last  <= 1'b0;
    end else begin
      do_valid <= s1_valid;
      do_last  <= s1_last;
      if (s1_valid) begin
        do_re  <= nrm_re;
        do_im  <= nrm_im;
        do_exp <= s1_exp;
      end
    end
  end

endmodule

// File: tb/tb_cbfp_norm.sv
// tb_cbfp_norm: directed, table-driven bench for cbfp_norm at default
// parameters. Each table row describes a block holding up to two non-zero
// components plus the hand-computed exponent and outputs for them; every
// other output component is expected to be zero.

module tb_cbfp_norm;

  localparam int IW    = 23;
  localparam int OW    = 11;
  localparam int LANES = 16;
  localparam int BB    = 4;
  localparam int EW    = 5;
  localparam int NVEC  = 7;

  logic                clk = 1'b0;
  logic                rstn;
  logic                clr;
  logic                di_valid;
  logic [LANES*IW-1:0] di_re;
  logic [LANES*IW-1:0] di_im;
  logic                do_valid;
  logic                do_last;
  logic [LANES*OW-1:0] do_re;
  logic [LANES*OW-1:0] do_im;
  logic [EW-1:0]       do_exp;

  cbfp_norm dut (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .di_valid (di_valid),
    .di_re    (di_re),
    .di_im    (di_im),
    .do_valid (do_valid),
    .do_last  (do_last),
    .do_re    (do_re),
    .do_im    (do_im),
    .do_exp   (do_exp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int b1, l1, im1, v1;  // first component: beat, lane, is-imag, value
    int b2, l2, im2, v2;  // second component (b2 = -1 when unused)
    int e;                // expected do_exp
    int o1, o2;           // expected outputs for the two components
  } vec_t;

  typedef struct {
    logic [LANES*OW-1:0] re;
    logic [LANES*OW-1:0] im;
    logic [EW-1:0]       ex;
    logic                last;
    int                  ecyc;
  } obs_t;

  vec_t tbl [NVEC];
  obs_t q [$];
  int   cyc = 0;
  int   stray = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every valid output beat with the edge index it appeared on.
  always @(posedge clk) begin
    #1;
    if (do_valid) q.push_back('{do_re, do_im, do_exp, do_last, cyc});
    else if (do_last) stray++;
  end

  function automatic int slot_val(int vi, int b, int l, int im, bit want_out);
    if (tbl[vi].b1 == b && tbl[vi].l1 == l && tbl[vi].im1 == im)
      return want_out ? tbl[vi].o1 : tbl[vi].v1;
    if (tbl[vi].b2 == b && tbl[vi].l2 == l && tbl[vi].im2 == im)
      return want_out ? tbl[vi].o2 : tbl[vi].v2;
    return 0;
  endfunction

  function automatic logic [LANES*IW-1:0] mk_in(int vi, int b, int im);
    logic [LANES*IW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[l*IW +: IW] = IW'(slot_val(vi, b, l, im, 1'b0));
    return r;
  endfunction

  function automatic logic [LANES*OW-1:0] mk_out(int vi, int b, int im);
    logic [LANES*OW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[l*OW +: OW] = OW'(slot_val(vi, b, l, im, 1'b1));
    return r;
  endfunction

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [LANES*OW-1:0] got,
                         input logic [LANES*OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_vec(input int i, input int b1, input int l1, input int im1,
                         input int v1, input int b2, input int l2, input int im2,
                         input int v2, input int e, input int o1, input int o2);
    tbl[i] = '{b1, l1, im1, v1, b2, l2, im2, v2, e, o1, o2};
  endtask

  task automatic idle();
    @(negedge clk);
    di_valid = 1'b0;
    di_re    = '0;
    di_im    = '0;
  endtask

  // Drive one block; gaps inserts an idle cycle carrying junk between beats.
  task automatic send_block(input int vi, input bit gaps, output int acc);
    acc = 0;
    for (int b = 0; b < BB; b++) begin
      @(negedge clk);
      di_valid = 1'b1;
      di_re    = mk_in(vi, b, 0);
      di_im    = mk_in(vi, b, 1);
      if (b == BB - 1) acc = cyc + 1;
      if (gaps && b < BB - 1) begin
        @(negedge clk);
        di_valid = 1'b0;
        di_re    = {LANES{23'h400000}};
        di_im    = {LANES{23'h400000}};
      end
    end
  endtask

  task automatic wait_q(input int n, input int budget);
    int k;
    k = 0;
    while (q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q.size() < n) begin
      checks++;
      failures++;
      $display("FAIL wait_q: got %0d beats expected %0d", q.size(), n);
    end
  endtask

  task automatic check_block(input int vi, input int acc, input int qi);
    if (q.size() < qi + BB) return;
    for (int b = 0; b < BB; b++) begin
      chk_vec($sformatf("v%0d_b%0d_re", vi, b), q[qi+b].re, mk_out(vi, b, 0));
      chk_vec($sformatf("v%0d_b%0d_im", vi, b), q[qi+b].im, mk_out(vi, b, 1));
      chk_int($sformatf("v%0d_b%0d_exp", vi, b), int'(q[qi+b].ex), tbl[vi].e);
      chk_int($sformatf("v%0d_b%0d_last", vi, b), int'(q[qi+b].last), (b == BB - 1) ? 1 : 0);
      chk_int($sformatf("v%0d_b%0d_cyc", vi, b), q[qi+b].ecyc, acc + 2 + b);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk_int({tag, "_valid"}, int'(do_valid), 0);
    chk_int({tag, "_last"}, int'(do_last), 0);
    chk_vec({tag, "_re"}, do_re, '0);
    chk_vec({tag, "_im"}, do_im, '0);
    chk_int({tag, "_exp"}, int'(do_exp), 0);
  endtask

  initial begin
    int acc;
    int a0, a1, a2, a3;

    // All zero: exponent clipped, left shift of zero.
    set_vec(0, 0, 0, 0, 0, -1, 0, 0, 0, 16, 0, 0);
    // 1023: exponent 12, no shift.
    set_vec(1, 2, 5, 1, 1023, -1, 0, 0, 0, 12, 1023, 0);
    // -2^22 forces E=0, right shift by 12.
    set_vec(2, 0, 0, 0, -4194304, 3, 15, 1, 4096, 0, -1024, 1);
`ifdef CBFP_ROUND_EN
    set_vec(3, 1, 7, 0, 3074, -1, 0, 0, 0, 10, 769, 0);
    set_vec(4, 1, 2, 1, 4194303, 3, 3, 0, 8191, 0, 1023, 2);
`else
    set_vec(3, 1, 7, 0, 3074, -1, 0, 0, 0, 10, 768, 0);
    set_vec(4, 1, 2, 1, 4194303, 3, 3, 0, 8191, 0, 1023, 1);
`endif
    // Small values: clipped to 16, left shift by 4.
    set_vec(5, 0, 1, 0, 5, 3, 8, 1, -3, 16, 80, -48);
    // E=14 from -256, left shift by 2.
    set_vec(6, 2, 9, 1, -256, 0, 4, 0, 100, 14, -1024, 400);

    rstn     = 1'b0;
    clr      = 1'b0;
    di_valid = 1'b0;
    di_re    = '0;
    di_im    = '0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rstn = 1'b1;

    // Single blocks from the table.
    for (int vi = 0; vi < NVEC; vi++) begin
      q.delete();
      send_block(vi, 1'b0, acc);
      idle();
      wait_q(BB, 20);
      check_block(vi, acc, 0);
      repeat (3) @(negedge clk);
      chk_int($sformatf("v%0d_beats", vi), q.size(), BB);
    end

    // Three full-rate blocks, then one with gaps.
    q.delete();
    send_block(1, 1'b0, a0);
    send_block(2, 1'b0, a1);
    send_block(3, 1'b0, a2);
    send_block(5, 1'b1, a3);
    idle();
    wait_q(4 * BB, 60);
    check_block(1, a0, 0);
    check_block(2, a1, BB);
    check_block(3, a2, 2 * BB);
    check_block(5, a3, 3 * BB);
    repeat (3) @(negedge clk);
    chk_int("stream_beats", q.size(), 4 * BB);

    // clr after beat 1 discards the partial block and the same-cycle beat.
    q.delete();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      di_valid = 1'b1;
      di_re    = mk_in(2, b, 0);
      di_im    = mk_in(2, b, 1);
    end
    @(negedge clk);
    clr      = 1'b1;
    di_valid = 1'b1;
    di_re    = {LANES{23'h400000}};
    di_im    = {LANES{23'h400000}};
    @(negedge clk);
    clr      = 1'b0;
    di_valid = 1'b0;
    send_block(0, 1'b0, acc);
    idle();
    wait_q(BB, 20);
    check_block(0, acc, 0);
    repeat (3) @(negedge clk);
    chk_int("clr_abort_beats", q.size(), BB);

    // clr right after the final beat cancels that block's output.
    q.delete();
    send_block(1, 1'b0, acc);
    @(negedge clk);
    di_valid = 1'b0;
    clr      = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (8) @(negedge clk);
    chk_int("clr_cancel_beats", q.size(), 0);

    // Asynchronous reset in the middle of an output block.
    q.delete();
    send_block(3, 1'b0, acc);
    idle();
    wait_q(2, 20);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_zero_outputs("midreset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);

    // Reset inside a partial block: the next block starts at beat 0.
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      di_valid = 1'b1;
      di_re    = mk_in(2, b, 0);
      di_im    = mk_in(2, b, 1);
    end
    @(negedge clk);
    di_valid = 1'b0;
    rstn     = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    q.delete();
    send_block(1, 1'b0, acc);
    idle();
    wait_q(BB, 20);
    check_block(1, acc, 0);
    repeat (3) @(negedge clk);
    chk_int("post_reset_beats", q.size(), BB);

    chk_int("stray_last", stray, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
